// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/HALT fetch sequencer with trap, redirect
// and back-pressure handling plus an accepted-fetch counter.
module pc_gen #(
    parameter int unsigned        XLEN      = 32,
    parameter logic [XLEN-1:0]    RESET_VEC = '0,
    parameter logic [XLEN-1:0]    TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int unsigned        INC       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic            halt_req,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc_seq,
    output logic            misalign_err,
    output logic            halted,
    output logic [XLEN-1:0] fetch_count
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [XLEN-1:0] INC_V    = XLEN'(INC);
    localparam logic [XLEN-1:0] INC_MASK = XLEN'(INC - 1);

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] count_next;
    logic            misalign_next;
    logic            accept;

    assign accept  = fetch_valid & fetch_ready & ~stall;
    assign npc_seq = pc + INC_V;

    // State and output registers; fetch_valid/halted mirror the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_BOOT;
            pc           <= RESET_VEC;
            fetch_count  <= '0;
            misalign_err <= 1'b0;
            fetch_valid  <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            fetch_count  <= count_next;
            misalign_err <= misalign_next;
            fetch_valid  <= (state_next == S_RUN);
            halted       <= (state_next == S_HALT);
        end
    end

    // Next-state logic: trap beats redirect beats sequential advance.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        count_next    = fetch_count;
        misalign_next = 1'b0;

        if (accept) begin
            count_next = fetch_count + XLEN'(1);
        end

        if (trap_valid) begin
            pc_next    = TRAP_VEC;
            state_next = S_RUN;
        end else if (redirect_valid && (state != S_BOOT)) begin
            if ((redirect_pc & INC_MASK) == '0) begin
                pc_next = redirect_pc;
            end else begin
                pc_next       = TRAP_VEC;
                misalign_next = 1'b1;
            end
            state_next = S_RUN;
        end else begin
            if (accept) begin
                pc_next = npc_seq;
            end
            case (state)
                S_BOOT:  state_next = S_RUN;
                S_RUN:   if (halt_req) state_next = S_HALT;
                S_HALT:  state_next = S_HALT;
                default: state_next = S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a behavioural model pushes expected outputs per
// cycle, which are popped and compared one edge later; an 8-bit instance covers wrap.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int unsigned BOOT = 0, RUN = 1, HALT = 2;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        hlt;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, trap_valid, halt_req, fetch_ready;
    logic [31:0] redirect_pc;
    logic        fetch_valid, misalign_err, halted;
    logic [31:0] pc, npc_seq, fetch_count;

    logic        rst8, stall8, rv8, tv8, halt8, ready8;
    logic [7:0]  rpc8;
    logic        fv8, mis8, halted8;
    logic [7:0]  pc8, npc8, cnt8;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q[$];
    int unsigned m_state;
    logic [31:0] m_pc, m_cnt;
    logic        m_mis;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .trap_valid(trap_valid), .halt_req(halt_req),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .pc(pc),
        .npc_seq(npc_seq), .misalign_err(misalign_err), .halted(halted),
        .fetch_count(fetch_count)
    );

    pc_gen #(.XLEN(8), .RESET_VEC(8'h00), .TRAP_VEC(8'h80), .INC(4)) dut8 (
        .clk(clk), .rst(rst8), .stall(stall8), .redirect_valid(rv8),
        .redirect_pc(rpc8), .trap_valid(tv8), .halt_req(halt8),
        .fetch_ready(ready8), .fetch_valid(fv8), .pc(pc8),
        .npc_seq(npc8), .misalign_err(mis8), .halted(halted8),
        .fetch_count(cnt8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference model by one edge and queue its prediction.
    task automatic cycle(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                         input logic tv, input logic hr, input logic rdy);
        logic acc;
        exp_t e;
        exp_t o;
        rst = r; stall = st; redirect_valid = rv; redirect_pc = rpc;
        trap_valid = tv; halt_req = hr; fetch_ready = rdy;
        acc = (m_state == RUN) && rdy && !st;
        if (r) begin
            m_pc = RV; m_state = BOOT; m_cnt = 0; m_mis = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (acc) m_cnt = m_cnt + 1;
            if (tv) begin
                m_pc = TV; m_state = RUN;
            end else if (rv && m_state != BOOT) begin
                if (rpc % 4 == 0) m_pc = rpc;
                else begin m_pc = TV; m_mis = 1'b1; end
                m_state = RUN;
            end else begin
                if (acc) m_pc = m_pc + 4;
                if (m_state == BOOT) m_state = RUN;
                else if (m_state == RUN && hr) m_state = HALT;
            end
        end
        e.pc = m_pc; e.fv = (m_state == RUN); e.hlt = (m_state == HALT);
        e.mis = m_mis; e.cnt = m_cnt;
        q.push_back(e);
        @(posedge clk); #1;
        o = q.pop_front();
        check("pc", 64'(pc), 64'(o.pc));
        check("fetch_valid", 64'(fetch_valid), 64'(o.fv));
        check("halted", 64'(halted), 64'(o.hlt));
        check("misalign_err", 64'(misalign_err), 64'(o.mis));
        check("fetch_count", 64'(fetch_count), 64'(o.cnt));
        check("npc_seq", 64'(npc_seq), 64'(o.pc + 32'd4));
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, rdy);
    endtask

    task automatic cycle8(input logic r, input logic rv, input logic [7:0] rpc, input logic hr,
                          input logic rdy, input logic [7:0] epc, input logic efv,
                          input logic ehlt, input logic [7:0] ecnt);
        exp_t e;
        exp_t o;
        rst8 = r; stall8 = 1'b0; rv8 = rv; rpc8 = rpc; tv8 = 1'b0; halt8 = hr; ready8 = rdy;
        e.pc = 32'(epc); e.fv = efv; e.hlt = ehlt; e.mis = 1'b0; e.cnt = 32'(ecnt);
        q.push_back(e);
        @(posedge clk); #1;
        o = q.pop_front();
        check("pc8", 64'(pc8), 64'(o.pc));
        check("fetch_valid8", 64'(fv8), 64'(o.fv));
        check("halted8", 64'(halted8), 64'(o.hlt));
        check("fetch_count8", 64'(cnt8), 64'(o.cnt));
    endtask

    initial begin
        m_state = BOOT; m_pc = RV; m_cnt = 0; m_mis = 1'b0;
        rst8 = 1'b1; stall8 = 1'b0; rv8 = 1'b0; rpc8 = 8'h0; tv8 = 1'b0; halt8 = 1'b0; ready8 = 1'b0;

        // Reset then sequential fetch: BOOT edge, RUN at RESET_VEC, four accepts.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("reset_pc", 64'(pc), 64'(RV));
        check("reset_fv", 64'(fetch_valid), 64'd0);
        idle(1'b1);
        check("boot_fv", 64'(fetch_valid), 64'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("seq_pc", 64'(pc), 64'h10);
        check("seq_cnt", 64'(fetch_count), 64'd4);

        // Back-pressure at pc = 8.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1); idle(1'b1);
        for (int i = 0; i < 3; i++) idle(1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("bp_pc", 64'(pc), 64'h8);
        check("bp_cnt", 64'(fetch_count), 64'd2);

        // Priority: trap over aligned redirect and accept; then misaligned redirect.
        cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        check("prio_pc", 64'(pc), 64'(TV));
        check("prio_mis", 64'(misalign_err), 64'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
        check("mis_pc", 64'(pc), 64'(TV));
        check("mis_pulse", 64'(misalign_err), 64'd1);
        idle(1'b0);
        check("mis_clear", 64'(misalign_err), 64'd0);

        // Halt with an accepted fetch at 0x20, then redirect out of HALT.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("halt_pc", 64'(pc), 64'h24);
        check("halt_flag", 64'(halted), 64'd1);
        check("halt_fv", 64'(fetch_valid), 64'd0);
        check("halt_cnt", 64'(fetch_count), 64'd1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        check("unhalt_pc", 64'(pc), 64'h80);
        check("unhalt_fv", 64'(fetch_valid), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("halt_trap_pc", 64'(pc), 64'(TV));

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 9) == 0), 32'($urandom_range(0, 255)),
                  1'($urandom_range(0, 20) == 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 3) != 0));
        end

        // 8-bit instance: wrap from 0xFC, halt, reset during HALT.
        cycle8(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0);
        cycle8(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0);
        cycle8(1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, 8'hFC, 1'b1, 1'b0, 8'd0);
        cycle8(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd1);
        check("wrap_npc8", 64'(npc8), 64'h04);
        cycle8(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1);
        cycle8(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0);
        cycle8(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC and counter width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, meaning PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning PC loaded on trap or misaligned redirect.
REQ-004 SHALL have parameter INC, default 4, meaning sequential PC increment in bytes (power of two).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port stall, input, 1, meaning hold PC (pipeline back-pressure).
REQ-008 SHALL have port redirect_valid, input, 1, meaning branch/jump taken this cycle.
REQ-009 SHALL have port redirect_pc, input, XLEN, meaning redirect target.
REQ-010 SHALL have port trap_valid, input, 1, meaning exception; jump to TRAP_VEC.
REQ-011 SHALL have port halt_req, input, 1, meaning stop fetching.
REQ-012 SHALL have port fetch_ready, input, 1, meaning instruction memory accepts the current fetch.
REQ-013 SHALL have port fetch_valid, output, 1, meaning pc is a valid fetch request.
REQ-014 SHALL have port pc, output, XLEN, meaning current fetch address (registered).
REQ-015 SHALL have port npc_seq, output, XLEN, meaning pc + INC, combinational, modulo 2^XLEN.
REQ-016 SHALL have port misalign_err, output, 1, meaning one-cycle pulse for a misaligned redirect.
REQ-017 SHALL have port halted, output, 1, meaning FSM is in HALT.
REQ-018 SHALL have port fetch_count, output, XLEN, meaning number of accepted fetches since reset.

Function
REQ-019 SHALL implement an FSM with states BOOT, RUN, HALT; BOOT -> RUN unconditionally after one cycle.
REQ-020 SHALL drive fetch_valid = 1 only in RUN; 0 in BOOT and HALT.
REQ-021 SHALL define accept = fetch_valid & fetch_ready & ~stall.
REQ-022 SHALL update pc per cycle with priority: trap_valid, then redirect_valid, then accept, else hold.
REQ-023 SHALL load TRAP_VEC on trap_valid in any non-reset state, and enter RUN.
REQ-024 SHALL load redirect_pc on redirect_valid when redirect_pc mod INC = 0, in RUN or HALT, ignoring stall and fetch_ready, and enter RUN.
REQ-025 SHALL, on redirect_valid with redirect_pc mod INC != 0, load TRAP_VEC, assert misalign_err next cycle for exactly one cycle, and enter RUN.
REQ-026 SHALL load npc_seq on accept; pc wraps from 2^XLEN - INC to 0.
REQ-027 SHALL hold pc stable while fetch_valid = 1 and accept = 0, unless trap or redirect applies; a redirect abandons the unaccepted fetch.
REQ-028 SHALL move RUN -> HALT on halt_req with no trap/redirect; in HALT pc holds, halted = 1, and halt_req is ignored.
REQ-029 SHALL let a fetch accepted in the halt_req cycle complete: pc advances and fetch_count increments.
REQ-030 SHALL make trap_valid and redirect_valid override halt_req in the same cycle.
REQ-031 SHALL increment fetch_count by 1 per accept, wrapping modulo 2^XLEN; it does not count redirects or traps.
REQ-032 SHALL register all outputs except npc_seq.

Reset
REQ-033 SHALL, while rst = 1 at a clock edge, set pc = RESET_VEC, state = BOOT, fetch_count = 0, misalign_err = 0, halted = 0, fetch_valid = 0.
REQ-034 SHALL let rst override all other inputs, including mid-fetch, mid-halt and a simultaneous trap.
REQ-035 SHALL produce the first fetch_valid = 1, at pc = RESET_VEC, two edges after rst deasserts: BOOT edge, then RUN.

Verification
REQ-036 Sequential: reset, fetch_ready = 1 for 4 accepts -> pc = 0,4,8,12,16; fetch_count = 4.
REQ-037 Back-pressure: fetch_ready = 0 for 3 cycles at pc = 8, then stall = 1 for 2 cycles with ready = 1 -> pc holds 8 for 5 cycles, fetch_count unchanged.
REQ-038 Priority: trap_valid, redirect_valid (0x40) and accept in one cycle -> pc = TRAP_VEC, misalign_err = 0; redirect_valid (0x42) -> pc = TRAP_VEC, misalign_err pulses one cycle.
REQ-039 Halt: halt_req with accept at pc = 0x20 -> pc = 0x24, halted = 1, fetch_valid = 0; then redirect 0x80 -> RUN, pc = 0x80.
REQ-040 Wrap/reset: XLEN = 8, pc = 0xFC, accept -> pc = 0x00; rst asserted during HALT -> pc = RESET_VEC, fetch_count = 0, BOOT.
